// File: rtl/command_keypad_entry_if.sv
// Keypad/button pins and command outputs of the keypad entry block.
// The slave side is the entry logic; the master side is the keypad and its consumer.
interface command_keypad_entry_if;
  logic [3:0]  col_n;
  logic        run_btn;
  logic        clr_btn;
  logic [3:0]  row_n;
  logic [11:0] command;
  logic        run;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [1:0]  digit_count;

  modport master (
    output col_n, run_btn, clr_btn,
    input  row_n, command, run, key_valid, key_code, digit_count
  );

  modport slave (
    input  col_n, run_btn, clr_btn,
    output row_n, command, run, key_valid, key_code, digit_count
  );
endinterface

// File: rtl/command_keypad_entry.sv
// Scans and debounces a 4x4 hex keypad plus run/clear buttons, assembles a
// three-digit command word and issues a one-cycle run strobe.
//   state    | meaning
//   SCAN     | walk rows, look for a single low column on each tick
//   DEBOUNCE | row held, candidate key must stay stable for DEBOUNCE_TICKS ticks
//   HELD     | key accepted, wait for DEBOUNCE_TICKS all-high ticks before rescanning
module command_keypad_entry #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  command_keypad_entry_if.slave kp
);
  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  logic [3:0]    col_m, col_s;
  logic [1:0]    btn_m, btn_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [DW-1:0] btn_cnt [2];
  logic [1:0]    btn_lvl;
  logic [1:0]    btn_rise;

  state_t        state, state_nx;
  logic [1:0]    row, row_nx;
  logic [1:0]    cand_col, cand_nx;
  logic [DW-1:0] db_cnt, db_nx;
  logic [1:0]    col_idx;
  logic          one_low;
  logic          accept;
  logic [3:0]    code_new;

  logic [3:0]    row_n_q;
  logic [11:0]   command_q, command_nx;
  logic [1:0]    digit_q, digit_nx;
  logic          run_q, run_nx;
  logic          key_valid_q;
  logic [3:0]    key_code_q;

  // Columns idle high, so their synchronisers reset high to avoid a phantom all-low sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      btn_m <= 2'b00;
      btn_s <= 2'b00;
    end else begin
      col_m <= kp.col_n;
      col_s <= col_m;
      btn_m <= {kp.clr_btn, kp.run_btn};
      btn_s <= btn_m;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Bit 0 is run, bit 1 is clear.
  always_comb begin
    for (int i = 0; i < 2; i++)
      btn_rise[i] = tick && btn_s[i] && !btn_lvl[i] && (btn_cnt[i] == DB_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_lvl <= 2'b00;
      for (int i = 0; i < 2; i++) btn_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] != btn_lvl[i]) begin
          if (btn_cnt[i] == DB_LAST) begin
            btn_lvl[i] <= btn_s[i];
            btn_cnt[i] <= '0;
          end else begin
            btn_cnt[i] <= btn_cnt[i] + 1'b1;
          end
        end else begin
          btn_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    one_low = 1'b1;
    col_idx = 2'd0;
    case (col_s)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SCAN;
      row      <= 2'd0;
      cand_col <= 2'd0;
      db_cnt   <= '0;
    end else begin
      state    <= state_nx;
      row      <= row_nx;
      cand_col <= cand_nx;
      db_cnt   <= db_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row;
    cand_nx  = cand_col;
    db_nx    = db_cnt;
    accept   = 1'b0;
    case (state)
      SCAN: if (tick) begin
        if (one_low) begin
          cand_nx  = col_idx;
          db_nx    = DW'(1);
          state_nx = DEBOUNCE;
        end else begin
          row_nx = row + 2'd1;
        end
      end
      DEBOUNCE: if (tick) begin
        if (one_low && (col_idx == cand_col)) begin
          if (db_cnt == DB_LAST) begin
            accept   = 1'b1;
            db_nx    = '0;
            state_nx = HELD;
          end else begin
            db_nx = db_cnt + 1'b1;
          end
        end else begin
          row_nx   = row + 2'd1;
          state_nx = SCAN;
        end
      end
      HELD: if (tick) begin
        if (col_s == 4'hF) begin
          if (db_cnt == DB_LAST) begin
            db_nx    = '0;
            row_nx   = row + 2'd1;
            state_nx = SCAN;
          end else begin
            db_nx = db_cnt + 1'b1;
          end
        end else begin
          db_nx = '0;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  assign code_new = {row, cand_col};

  // Clear beats run beats key; run sees the pre-shift digit count.
  always_comb begin
    command_nx = command_q;
    digit_nx   = digit_q;
    run_nx     = 1'b0;
    if (btn_rise[1]) begin
      command_nx = '0;
      digit_nx   = 2'd0;
    end else begin
      if (btn_rise[0] && (digit_q == 2'd3)) begin
        run_nx   = 1'b1;
        digit_nx = 2'd0;
      end
      if (accept) begin
        command_nx = {command_q[7:0], code_new};
        digit_nx   = (digit_nx == 2'd3) ? 2'd3 : digit_nx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_n_q     <= 4'b1110;
      command_q   <= '0;
      digit_q     <= 2'd0;
      run_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      row_n_q     <= ~(4'b0001 << row_nx);
      command_q   <= command_nx;
      digit_q     <= digit_nx;
      run_q       <= run_nx;
      key_valid_q <= accept;
      if (accept) key_code_q <= code_new;
    end
  end

  assign kp.row_n       = row_n_q;
  assign kp.command     = command_q;
  assign kp.digit_count = digit_q;
  assign kp.run         = run_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_code    = key_code_q;
endmodule

// File: tb/tb_command_keypad_entry.sv
// Scoreboard bench for command_keypad_entry: a physical keypad model drives the
// columns, a digit-list reference model predicts accepted keys and run strobes.
module tb_command_keypad_entry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  command_keypad_entry_if kp_if ();

  command_keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp_if.slave)
  );

  logic [15:0] pressed;
  logic [3:0]  cols;
  logic        run_b, clr_b;

  // A pressed key pulls its column low only while its row is driven low.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp_if.row_n[r]) cols[c] = 1'b0;
  end
  assign kp_if.col_n   = cols;
  assign kp_if.run_btn = run_b;
  assign kp_if.clr_btn = clr_b;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {int code; int cmd; int cnt;} key_exp_t;
  key_exp_t key_q[$];
  int       run_q[$];
  int       m_cmd = 0;
  int       m_cnt = 0;

  task automatic model_key(input int k);
    m_cmd = ((m_cmd * 16) + k) % 4096;
    m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
    key_q.push_back('{k, m_cmd, m_cnt});
  endtask

  task automatic model_run();
    if (m_cnt == 3) begin
      m_cnt = 0;
      run_q.push_back(m_cmd);
    end
  endtask

  task automatic model_clr();
    m_cmd = 0;
    m_cnt = 0;
  endtask

  key_exp_t ke;
  int       re;
  always @(negedge clk) begin
    if (rst_n) begin
      check("row_one_low", $countones(~kp_if.row_n), 1);
      if (kp_if.key_valid) begin
        if (key_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL key_valid_unexpected: got pulse code=0x%0h, expected none", kp_if.key_code);
        end else begin
          ke = key_q.pop_front();
          check("key_code", kp_if.key_code, ke.code);
          check("key_command", kp_if.command, ke.cmd);
          check("key_digit_count", kp_if.digit_count, ke.cnt);
        end
      end
      if (kp_if.run) begin
        if (run_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL run_unexpected: got pulse command=0x%0h, expected none", kp_if.command);
        end else begin
          re = run_q.pop_front();
          check("run_command", kp_if.command, re);
          check("run_digit_count", kp_if.digit_count, 0);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_entry(input int k, input int hold = 40, input int gap = 32);
    model_key(k);
    pressed[k] = 1'b1;
    cyc(hold);
    pressed[k] = 1'b0;
    cyc(gap);
  endtask

  task automatic btn_entry(input bit r, input bit c);
    if (c) model_clr();
    else if (r) model_run();
    run_b = r;
    clr_b = c;
    cyc(30);
    run_b = 1'b0;
    clr_b = 1'b0;
    cyc(32);
  endtask

  // Returns on the first negedge after the given row becomes driven.
  task automatic wait_row(input int r);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << r);
    n = 0;
    while (kp_if.row_n == tgt && n < 100) begin cyc(1); n++; end
    while (kp_if.row_n != tgt && n < 100) begin cyc(1); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_row_timeout: got row_n=%b, expected row %0d driven", kp_if.row_n, r);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_command"}, kp_if.command, m_cmd);
    check({tag, "_digit_count"}, kp_if.digit_count, m_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_row;
    logic [3:0] prev_row;
    int changes, op, k;

    pressed = '0;
    run_b   = 1'b0;
    clr_b   = 1'b0;
    rst_n   = 1'b0;
    cyc(3);
    check("rst_row_n", kp_if.row_n, 4'b1110);
    check("rst_command", kp_if.command, 0);
    check("rst_digit_count", kp_if.digit_count, 0);
    check("rst_run", kp_if.run, 0);
    check("rst_key_valid", kp_if.key_valid, 0);
    check("rst_key_code", kp_if.key_code, 0);
    rst_n = 1'b1;

    // Tick every 4 cycles from reset release, so the row index is n/4.
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) cyc(1);
      exp_row = ~(4'b0001 << ((n / 4) % 4));
      check("row_walk", kp_if.row_n, exp_row);
    end

    key_entry(6);
    cyc(200);
    check_outputs("single_key");

    key_entry(1);
    key_entry(2);
    key_entry(3);
    check_outputs("three_keys");
    btn_entry(1'b1, 1'b0);
    check_outputs("after_run");
    key_entry(4);
    check_outputs("after_key4");

    // Key 5 visible on only two ticks of its row.
    wait_row(1);
    pressed[5] = 1'b1;
    cyc(8);
    pressed[5] = 1'b0;
    cyc(40);
    check_outputs("short_press");

    // Bounce across alternate ticks, then a stable press.
    model_key(5);
    wait_row(1);
    for (int i = 0; i < 4; i++) begin
      pressed[5] = (i % 2 == 0);
      cyc(4);
    end
    pressed[5] = 1'b1;
    cyc(40);
    pressed[5] = 1'b0;
    cyc(32);
    check_outputs("bounce");

    btn_entry(1'b1, 1'b0);
    check_outputs("run_gated");
    key_entry(7);
    check_outputs("three_again");
    btn_entry(1'b1, 1'b1);
    check_outputs("clear_beats_run");

    // Two columns low on one row is never a key.
    pressed[4] = 1'b1;
    pressed[5] = 1'b1;
    changes = 0;
    prev_row = kp_if.row_n;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (kp_if.row_n != prev_row) changes++;
      prev_row = kp_if.row_n;
    end
    pressed[4] = 1'b0;
    pressed[5] = 1'b0;
    check("ghost_scan_advances", (changes >= 8) ? 1 : 0, 1);
    cyc(32);
    check_outputs("ghost");

    key_entry(9);
    wait_row(1);
    pressed[6] = 1'b1;
    cyc(6);
    rst_n = 1'b0;
    cyc(1);
    model_clr();
    check("midrst_row_n", kp_if.row_n, 4'b1110);
    check("midrst_command", kp_if.command, 0);
    check("midrst_digit_count", kp_if.digit_count, 0);
    check("midrst_run", kp_if.run, 0);
    check("midrst_key_valid", kp_if.key_valid, 0);
    check("midrst_key_code", kp_if.key_code, 0);
    pressed[6] = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(40);
    check_outputs("after_midrst");

    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 99);
      if (op < 70) begin
        k = $urandom_range(0, 15);
        key_entry(k, $urandom_range(40, 60), $urandom_range(32, 45));
      end else if (op < 88) begin
        btn_entry(1'b1, 1'b0);
      end else begin
        btn_entry(1'b0, 1'b1);
      end
    end
    cyc(50);

    check("pending_keys", key_q.size(), 0);
    check("pending_runs", run_q.size(), 0);
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
